// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types and defaults for the instruction fetch arbiter.
//   WIDTH            data/address width of the instruction memory
//   DEF_RESET_PC     PC loaded at reset
//   DEF_LAST_ADDR    highest legal word byte-address
//   DEF_DBG_MAX_WAIT cycles a debug request may be starved before forced grant
package imem_fetch_arbiter_pkg;

  localparam int unsigned WIDTH            = 32;
  localparam int unsigned DEF_DBG_MAX_WAIT = 4;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t DEF_RESET_PC  = 32'h0000_0000;
  localparam word_t DEF_LAST_ADDR = 32'd508;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // Payload held in the decode-facing output register.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_pkt_t;

  // A PC target is unusable if not word aligned or beyond the memory.
  function automatic logic bad_target(input word_t addr, input word_t last);
    return (addr[1:0] != 2'b00) || (addr > last);
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Decode-side fetch handshake plus debug read port.
//   out_valid/out_ready/out_instr/out_pc  fetched word toward decode
//   dbg_req/dbg_addr                      debug read request (held until granted)
//   dbg_gnt/dbg_rdata                     one-cycle grant with read data
// master: arbiter side, slave: decode / debug requester side.
interface imem_fetch_arbiter_if;
  import imem_fetch_arbiter_pkg::*;

  logic  out_valid;
  logic  out_ready;
  word_t out_instr;
  word_t out_pc;
  logic  dbg_req;
  word_t dbg_addr;
  logic  dbg_gnt;
  word_t dbg_rdata;

  modport master (
    output out_valid, out_instr, out_pc, dbg_gnt, dbg_rdata,
    input  out_ready, dbg_req, dbg_addr
  );

  modport slave (
    input  out_valid, out_instr, out_pc, dbg_gnt, dbg_rdata,
    output out_ready, dbg_req, dbg_addr
  );

endinterface

// File: rtl/imem_dbg_arb.sv
// Bounded-wait arbitration of the memory read port between fetch and debug.
//   clk, rst_n    clock, async active-low reset
//   dbg_req       debug request pending
//   fetch_want    fetch needs the port this cycle
//   dbg_addr, pc  candidate addresses
//   dbg_win_c     debug owns the port this cycle
//   mem_addr_c    selected memory address
module imem_dbg_arb
  import imem_fetch_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_DBG_MAX_WAIT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  dbg_req,
  input  logic  fetch_want,
  input  word_t dbg_addr,
  input  word_t pc,
  output logic  dbg_win_c,
  output word_t mem_addr_c
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Debug takes the port when fetch is idle or has starved it long enough.
  always_comb begin
    dbg_win_c  = dbg_req && (!fetch_want || (wait_cnt == CNT_W'(MAX_WAIT)));
    mem_addr_c = dbg_win_c ? dbg_addr : pc;
  end

  // Starvation counter, saturating, cleared on grant or withdrawn request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!dbg_req || dbg_win_c) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Instruction fetch sequencer: owns the PC, drives the combinational-read
// instruction memory, registers fetched words toward decode, shares the port
// with a debug reader, and handles redirect, halt/resume and PC faults.
//   clk, rst_n           clock, async active-low reset
//   imem_addr/imem_rdata memory address out, same-cycle read data in
//   bus (master)         decode handshake and debug read port
//   redirect_valid/pc    taken branch/jump target
//   halt_req/resume_req  stop / restart fetching
//   fault                sticky misaligned or out-of-range PC
//   state_o              current state encoding
module imem_fetch_arbiter
  import imem_fetch_arbiter_pkg::*;
#(
  parameter word_t       RESET_PC     = DEF_RESET_PC,
  parameter word_t       LAST_ADDR    = DEF_LAST_ADDR,
  parameter int unsigned DBG_MAX_WAIT = DEF_DBG_MAX_WAIT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output word_t                       imem_addr,
  input  word_t                       imem_rdata,
  imem_fetch_arbiter_if.master        bus,
  input  logic                        redirect_valid,
  input  word_t                       redirect_pc,
  input  logic                        halt_req,
  input  logic                        resume_req,
  output logic                        fault,
  output logic [1:0]                  state_o
);

  state_e     state;
  word_t      pc;
  fetch_pkt_t out_q;
  logic       out_valid_q;
  logic       fault_q;

  logic slot_free_c;
  logic redirect_act_c;
  logic redirect_bad_c;
  logic fetch_want_c;
  logic fetch_win_c;
  logic seq_bad_c;
  logic dbg_win_c;

  // Per-cycle decode of who uses the memory and what the PC does.
  always_comb begin
    slot_free_c    = !out_valid_q || bus.out_ready;
    redirect_act_c = redirect_valid && ((state == ST_FETCH) || (state == ST_HALTED));
    redirect_bad_c = bad_target(redirect_pc, LAST_ADDR);
    fetch_want_c   = (state == ST_FETCH) && slot_free_c && !redirect_act_c;
    fetch_win_c    = fetch_want_c && !dbg_win_c;
    seq_bad_c      = (pc + word_t'(4)) > LAST_ADDR;
  end

  imem_dbg_arb #(
    .MAX_WAIT (DBG_MAX_WAIT)
  ) u_dbg_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .dbg_req    (bus.dbg_req),
    .fetch_want (fetch_want_c),
    .dbg_addr   (bus.dbg_addr),
    .pc         (pc),
    .dbg_win_c  (dbg_win_c),
    .mem_addr_c (imem_addr)
  );

  // FSM, PC and decode-facing output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      // A fetch win refills the slot; otherwise flush or drain on transfer.
      if (fetch_win_c) begin
        out_q.pc    <= pc;
        out_q.instr <= imem_rdata;
        out_valid_q <= 1'b1;
      end else if (redirect_act_c || slot_free_c) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        ST_BOOT: state <= ST_FETCH;
        ST_FETCH, ST_HALTED: begin
          if ((redirect_act_c && redirect_bad_c) || (fetch_win_c && seq_bad_c)) begin
            fault_q <= 1'b1;
            state   <= ST_FAULT;
          end else begin
            if (redirect_act_c) begin
              pc <= redirect_pc;
            end else if (fetch_win_c) begin
              pc <= pc + word_t'(4);
            end
            if (halt_req) begin
              state <= ST_HALTED;
            end else if ((state == ST_HALTED) && resume_req) begin
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_FAULT;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_q.instr;
  assign bus.out_pc    = out_q.pc;
  assign bus.dbg_gnt   = dbg_win_c;
  assign bus.dbg_rdata = imem_rdata;
  assign fault         = fault_q;
  assign state_o       = state;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomized scoreboard bench for imem_fetch_arbiter.
module tb_imem_fetch_arbiter;
  import imem_fetch_arbiter_pkg::*;

  localparam int MAXW    = 4;
  localparam int LAST    = 508;
  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } gnt_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } wrd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  word_t       imem_addr;
  word_t       imem_rdata;
  logic        redirect_valid;
  word_t       redirect_pc;
  logic        halt_req;
  logic        resume_req;
  logic        fault;
  logic [1:0]  state_o;
  logic [31:0] mem [128];

  imem_fetch_arbiter_if bus ();

  imem_fetch_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .bus            (bus.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .fault          (fault),
    .state_o        (state_o)
  );

  assign imem_rdata = mem[imem_addr[8:2]];

  always #5 clk = ~clk;

  gnt_t gq[$];
  wrd_t fq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model state
  int          m_mode, m_pc, m_starve;
  bit          m_vld, m_fault, d_pend;
  logic [31:0] d_addr, m_addr_exp;

  int p_ready, p_redir, p_halt, p_resume, p_dbg, p_bad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit chance(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    resume_req     = 1'b0;
    bus.out_ready  = 1'b0;
    bus.dbg_req    = 1'b0;
    bus.dbg_addr   = '0;
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 0; m_starve = 0;
    m_vld = 0; m_fault = 0; d_pend = 0;
    m_addr_exp = '0;
    gq.delete();
    fq.delete();
  endtask

  // Called at a negedge: reset for one cycle, check reset values, release.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'(M_BOOT));
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.out_instr, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_gnt", 32'(bus.dbg_gnt), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;
  endtask

  // One cycle: check registered state, drive random stimulus, advance model.
  task automatic step();
    bit rv, rdy, hr, rs, dr, redir, xfer, freeslot, freq, dnow, fnow, bad;
    logic [31:0] rpc;
    gnt_t g;
    wrd_t w;
    cyc++;
    check("state_o", 32'(state_o), 32'(m_mode));
    check("fault", 32'(fault), 32'(m_fault));
    check("out_valid", 32'(bus.out_valid), 32'(m_vld));

    rdy = chance(p_ready);
    rv  = chance(p_redir);
    hr  = chance(p_halt);
    rs  = chance(p_resume);
    if (chance(p_bad)) begin
      if (chance(50)) rpc = 32'($urandom_range(127, 0)) * 4 + 32'($urandom_range(3, 1));
      else            rpc = 32'd512 + 32'($urandom_range(63, 0)) * 4;
    end else if (chance(30)) begin
      rpc = 32'(LAST) - 32'($urandom_range(4, 0)) * 4;
    end else begin
      rpc = 32'($urandom_range(127, 0)) * 4;
    end
    if (d_pend) begin
      dr = 1'b1;
    end else begin
      dr = chance(p_dbg);
      d_addr = 32'($urandom_range(127, 0)) * 4;
    end

    bus.out_ready  = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    resume_req     = rs;
    bus.dbg_req    = dr;
    bus.dbg_addr   = d_addr;

    redir    = rv && (m_mode == M_RUN || m_mode == M_HALT);
    xfer     = m_vld && rdy;
    freeslot = !m_vld || rdy;
    freq     = (m_mode == M_RUN) && freeslot && !redir;
    dnow     = dr && (!freq || m_starve >= MAXW);
    fnow     = freq && !dnow;
    m_addr_exp = dnow ? d_addr : 32'(m_pc);
    if (dnow) begin
      g.cyc = cyc; g.addr = d_addr; g.data = mem[d_addr[8:2]];
      gq.push_back(g);
    end
    m_starve = (dr && !dnow) ? ((m_starve < MAXW) ? m_starve + 1 : MAXW) : 0;
    d_pend   = dr && !dnow;
    if (xfer) m_vld = 0;
    if (redir && m_vld) begin
      fq.delete(fq.size() - 1);
      m_vld = 0;
    end
    if (fnow) begin
      w.pc = 32'(m_pc); w.instr = mem[m_pc / 4];
      fq.push_back(w);
      m_vld = 1;
    end
    bad = (rpc[1:0] != 2'b00) || (rpc > 32'(LAST));
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN || m_mode == M_HALT) begin
      if ((redir && bad) || (fnow && m_pc + 4 > LAST)) begin
        m_mode  = M_FAULT;
        m_fault = 1;
      end else begin
        if (redir) m_pc = int'(rpc);
        else if (fnow) m_pc = m_pc + 4;
        if (hr) m_mode = M_HALT;
        else if (m_mode == M_HALT && rs) m_mode = M_RUN;
      end
    end
    @(negedge clk);
  endtask

  task automatic knobs(input int rdy, input int rd, input int h, input int r,
                       input int d, input int b);
    p_ready = rdy; p_redir = rd; p_halt = h; p_resume = r; p_dbg = d; p_bad = b;
  endtask

  // Monitor: compares grants, transfers and the memory address as they appear.
  bit   mon_eg;
  gnt_t mon_g;
  wrd_t mon_w;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        mon_eg = (gq.size() > 0) && (gq[0].cyc == cyc);
        check("dbg_gnt", 32'(bus.dbg_gnt), 32'(mon_eg));
        check("imem_addr", imem_addr, m_addr_exp);
        if (bus.dbg_gnt && gq.size() > 0) begin
          mon_g = gq.pop_front();
          check("dbg_addr", imem_addr, mon_g.addr);
          check("dbg_rdata", bus.dbg_rdata, mon_g.data);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (fq.size() == 0) begin
            check("xfer_expected", 32'd1, 32'd0 + 32'(fq.size()));
          end else begin
            mon_w = fq.pop_front();
            check("out_pc", bus.out_pc, mon_w.pc);
            check("out_instr", bus.out_instr, mon_w.instr);
          end
        end
      end
    end
  end

  int fcnt;
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0]  = 32'h002081B3;
    mem[12] = 32'h00110293;
    mem[16] = 32'h002102E7;
    idle_inputs();
    knobs(100, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Straight-line fetch with decode always ready.
    repeat (30) step();
    // Back-pressure from decode.
    knobs(50, 0, 0, 0, 0, 0);
    repeat (60) step();
    // Debug held against a continuously busy fetch.
    knobs(100, 0, 0, 0, 100, 0);
    repeat (40) step();
    // Halt, debug while halted, resume.
    knobs(80, 0, 100, 0, 0, 0);
    repeat (3) step();
    knobs(80, 0, 0, 0, 100, 0);
    repeat (6) step();
    knobs(80, 0, 0, 100, 0, 0);
    repeat (10) step();

    // Mixed random traffic with redirects, faults and mid-stream resets.
    knobs(70, 8, 3, 20, 20, 10);
    fcnt = 0;
    for (int n = 0; n < 2500; n++) begin
      if (m_mode == M_FAULT) fcnt++;
      if (fcnt > 6 || (n % 700) == 699) begin
        fcnt = 0;
        do_reset();
      end
      step();
    end

    // Drain: halt fetching and let decode empty the slot.
    knobs(100, 0, 100, 0, 0, 0);
    repeat (10) step();
    check("fq_left", 32'(fq.size()), 32'd0);
    check("gq_left", 32'(gq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
